llc_bus_responder: RTL and testbench

Bus-side responder for the last-level cache. It accepts one bus operation at a time from the LLC (READ, WRITE, INVALIDATE, RWIM), broadcasts a snoop to the peer caches, and merges their snoop results. When needed it waits for a peer writeback, then runs the memory transaction and returns the merged snoop result to the LLC. It sits between the LLC's busOp/snoopResult interface and the shared memory port, and keeps transaction statistics.

---
 rtl/llc_bus_responder_if.sv | 38 +++
 rtl/llc_bus_responder.sv | 193 +++++++++++++++++++
 tb/tb_llc_bus_responder.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llc_bus_responder_if.sv
// Bus-side bundle between the LLC, the peer caches and the memory port.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_op/req_addr must be stable while req_valid is
// high. snoop_req and rsp_valid are single-cycle strobes, mem_req is held
// until the edge where mem_ack is sampled high.
interface llc_bus_responder_if #(
   parameter int N_AGENTS = 3
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [31:0]           req_addr;
   logic                  snoop_req;
   logic [1:0]            snoop_op;
   logic [31:0]           snoop_addr;
   logic [N_AGENTS-1:0]   snoop_valid;
   logic [2*N_AGENTS-1:0] snoop_res;
   logic                  wb_valid;
   logic                  mem_req;
   logic                  mem_we;
   logic                  mem_ack;
   logic                  rsp_valid;
   logic [1:0]            rsp_result;

   // Responder side
   modport slave (
      input  req_valid, req_op, req_addr, snoop_valid, snoop_res, wb_valid, mem_ack,
      output req_ready, snoop_req, snoop_op, snoop_addr, mem_req, mem_we,
             rsp_valid, rsp_result
   );

   // LLC / peer / memory side
   modport master (
      output req_valid, req_op, req_addr, snoop_valid, snoop_res, wb_valid, mem_ack,
      input  req_ready, snoop_req, snoop_op, snoop_addr, mem_req, mem_we,
             rsp_valid, rsp_result
   );
endinterface

// File: rtl/llc_bus_responder.sv
// LLC bus responder: accepts one bus operation, snoops the peers, merges
// their replies (HITM > HIT > NOHIT), optionally waits for a peer writeback,
// runs the memory transaction and returns the merged result to the LLC.
// Every output is a flop decoded from the next state, so outputs line up
// with the state register and no input reaches an output combinationally.
module llc_bus_responder #(
   parameter int N_AGENTS      = 3,
   parameter int SNOOP_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   llc_bus_responder_if.slave bus,
   output logic [31:0]       txn_count,
   output logic [31:0]       hitm_count,
   output logic [2:0]        state_dbg
);

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_INV   = 2'd2;
   localparam logic [1:0] OP_RWIM  = 2'd3;

   localparam logic [1:0] RES_HIT   = 2'd0;
   localparam logic [1:0] RES_HITM  = 2'd1;
   localparam logic [1:0] RES_NOHIT = 2'd2;
   localparam logic [1:0] RES_NONE  = 2'd3;

   localparam int CW = $clog2(SNOOP_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNOOP   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_WB_WAIT = 3'd3,
      ST_MEM     = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [31:0]           addr_q, addr_d;
   logic [N_AGENTS-1:0]   mask_q, mask_d;
   logic [1:0]            merge_q, merge_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            rsp_result_q, rsp_result_d;
   logic [31:0]           txn_q, txn_d;
   logic [31:0]           hitm_q, hitm_d;
   logic                  req_ready_q, req_ready_d;
   logic                  snoop_req_q, snoop_req_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [1:0]            fin_res;
   logic                  collect_exit;

   // Next-state, merge, counters and output decode
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      mask_d       = mask_q;
      merge_d      = merge_q;
      cnt_d        = cnt_q;
      rsp_result_d = rsp_result_q;
      txn_d        = txn_q;
      hitm_d       = hitm_q;
      fin_res      = RES_NONE;
      collect_exit = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // req_ready is high throughout IDLE, so valid alone accepts
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               addr_d  = bus.req_addr;
               state_d = (bus.req_op == OP_WRITE) ? ST_MEM : ST_SNOOP;
            end
         end
         ST_SNOOP: begin
            mask_d  = '0;
            merge_d = RES_NOHIT;
            // the first COLLECT cycle is cycle 1
            cnt_d   = CW'(1);
            state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            for (int i = 0; i < N_AGENTS; i++) begin
               if (bus.snoop_valid[i] && !mask_q[i]) begin
                  mask_d[i] = 1'b1;
                  if (bus.snoop_res[2*i +: 2] == RES_HITM) begin
                     merge_d = RES_HITM;
                  end else if ((bus.snoop_res[2*i +: 2] == RES_HIT) && (merge_d != RES_HITM)) begin
                     merge_d = RES_HIT;
                  end
               end
            end
            collect_exit = (&mask_d) || (cnt_q == CW'(SNOOP_TIMEOUT));
            if (collect_exit) begin
               if (op_q == OP_INV) begin
                  state_d = ST_DONE;
               end else if (merge_d == RES_HITM) begin
                  state_d = ST_WB_WAIT;
               end else begin
                  state_d = ST_MEM;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WB_WAIT: begin
            if (bus.wb_valid) begin
               state_d = ST_MEM;
            end
         end
         ST_MEM: begin
            if (bus.mem_ack) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Result and statistics are committed on entry to DONE so they are
      // already visible in the rsp_valid cycle.
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         fin_res      = (op_q == OP_WRITE) ? RES_NONE : merge_d;
         rsp_result_d = fin_res;
         txn_d        = txn_q + 32'd1;
         if (fin_res == RES_HITM) begin
            hitm_d = hitm_q + 32'd1;
         end
      end

      req_ready_d = (state_d == ST_IDLE);
      snoop_req_d = (state_d == ST_SNOOP);
      mem_req_d   = (state_d == ST_MEM);
      mem_we_d    = (state_d == ST_MEM) && (op_d == OP_WRITE);
      rsp_valid_d = (state_d == ST_DONE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_READ;
         addr_q       <= '0;
         mask_q       <= '0;
         merge_q      <= RES_NOHIT;
         cnt_q        <= '0;
         rsp_result_q <= RES_NONE;
         txn_q        <= '0;
         hitm_q       <= '0;
         req_ready_q  <= 1'b1;
         snoop_req_q  <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         mask_q       <= mask_d;
         merge_q      <= merge_d;
         cnt_q        <= cnt_d;
         rsp_result_q <= rsp_result_d;
         txn_q        <= txn_d;
         hitm_q       <= hitm_d;
         req_ready_q  <= req_ready_d;
         snoop_req_q  <= snoop_req_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.snoop_req  = snoop_req_q;
   assign bus.snoop_op   = op_q;
   assign bus.snoop_addr = addr_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign txn_count      = txn_q;
   assign hitm_count     = hitm_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_llc_bus_responder.sv
// Bench for llc_bus_responder: directed cases plus random transactions,
// each predicted by a transaction-level model of the responder.
module tb_llc_bus_responder;

   localparam int N_AGENTS      = 3;
   localparam int SNOOP_TIMEOUT = 8;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_INV   = 2'd2;
   localparam logic [1:0] OP_RWIM  = 2'd3;
   localparam logic [1:0] R_HIT    = 2'd0;
   localparam logic [1:0] R_HITM   = 2'd1;
   localparam logic [1:0] R_NOHIT  = 2'd2;
   localparam logic [1:0] R_NONE   = 2'd3;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] txn_count;
   logic [31:0] hitm_count;
   logic [2:0]  state_dbg;

   always #5 clk = ~clk;

   llc_bus_responder_if #(.N_AGENTS(N_AGENTS)) bus ();

   llc_bus_responder #(
      .N_AGENTS(N_AGENTS),
      .SNOOP_TIMEOUT(SNOOP_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .txn_count(txn_count),
      .hitm_count(hitm_count),
      .state_dbg(state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [1:0]  exp_q[$];
   logic [31:0] exp_txn  = 0;
   logic [31:0] exp_hitm = 0;

   // per-transaction stimulus description (collect-relative cycles, 0 = none)
   int          rep_cyc[N_AGENTS];
   logic [1:0]  rep_res[N_AGENTS];
   int          dup_cyc[N_AGENTS];
   logic [1:0]  dup_res[N_AGENTS];
   int          wb_dly;
   int          ack_dly;
   bit          spur;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int rank(input logic [1:0] r);
      if (r == R_HITM) return 2;
      if (r == R_HIT) return 1;
      return 0;
   endfunction

   task automatic idle_inputs();
      bus.req_valid   = 1'b0;
      bus.req_op      = 2'd0;
      bus.req_addr    = 32'd0;
      bus.snoop_valid = '0;
      bus.snoop_res   = '0;
      bus.wb_valid    = 1'b0;
      bus.mem_ack     = 1'b0;
   endtask

   task automatic set_agent(input int i, input int rc, input logic [1:0] rr,
                            input int dc, input logic [1:0] dr);
      rep_cyc[i] = rc;
      rep_res[i] = rr;
      dup_cyc[i] = dc;
      dup_res[i] = dr;
   endtask

   // Drives one transaction (starting just after a rising edge) and checks it
   // against the timing and result predicted from the responder's rules.
   task automatic run_txn(input logic [1:0] op, input logic [31:0] addr);
      int e, c_exit, c_m, c_wb, c_d, best, budget;
      int n_snoop, snoop_at, n_mem, mem_at, n_rsp, rsp_at, busy_bad, we_bad;
      bit all_in;
      logic [1:0] exp_res;
      logic [N_AGENTS-1:0] sv;
      logic [2*N_AGENTS-1:0] sr;

      // model: exit cycle of the reply window and merged result
      all_in = 1'b1;
      e = 0;
      for (int i = 0; i < N_AGENTS; i++) begin
         if (rep_cyc[i] < 1 || rep_cyc[i] > SNOOP_TIMEOUT) all_in = 1'b0;
         else if (rep_cyc[i] > e) e = rep_cyc[i];
      end
      if (!all_in) e = SNOOP_TIMEOUT;
      best = 0;
      for (int i = 0; i < N_AGENTS; i++) begin
         if (rep_cyc[i] >= 1 && rep_cyc[i] <= e && rank(rep_res[i]) > best) best = rank(rep_res[i]);
      end
      if (op == OP_WRITE) exp_res = R_NONE;
      else exp_res = (best == 2) ? R_HITM : (best == 1) ? R_HIT : R_NOHIT;

      c_exit = 0;
      c_wb   = 0;
      if (op == OP_WRITE) begin
         c_m = 1;
      end else begin
         c_exit = 1 + e;
         if (op == OP_INV) c_m = 0;
         else if (exp_res == R_HITM) begin
            c_wb = c_exit + 1 + wb_dly;
            c_m  = c_wb + 1;
         end else c_m = c_exit + 1;
      end
      c_d = (op == OP_INV) ? c_exit + 1 : c_m + ack_dly + 1;

      exp_q.push_back(exp_res);
      exp_txn = exp_txn + 1;
      if (exp_res == R_HITM) exp_hitm = exp_hitm + 1;

      // accept
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      @(negedge clk);
      check("accept_ready", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'($urandom);
      bus.req_addr  = $urandom;

      n_snoop = 0; snoop_at = 0; n_mem = 0; mem_at = 0;
      n_rsp = 0; rsp_at = 0; busy_bad = 0; we_bad = 0;
      budget = c_d + 3;
      for (int c = 1; c <= budget; c++) begin
         for (int i = 0; i < N_AGENTS; i++) begin
            sv[i] = 1'b0;
            sr[2*i +: 2] = 2'($urandom);
            if (rep_cyc[i] >= 1 && c == 1 + rep_cyc[i]) begin
               sv[i] = 1'b1;
               sr[2*i +: 2] = rep_res[i];
            end else if (dup_cyc[i] >= 1 && c == 1 + dup_cyc[i]) begin
               sv[i] = 1'b1;
               sr[2*i +: 2] = dup_res[i];
            end
         end
         bus.snoop_valid = sv;
         bus.snoop_res   = sr;
         bus.wb_valid    = (c_wb > 0) && ((c == c_wb) || (spur && c == c_exit));
         bus.mem_ack     = ((c_m > 0) && (c == c_m + ack_dly)) || (spur && c_m >= 2 && c == c_m - 1);

         @(negedge clk);
         if (bus.snoop_req) begin
            n_snoop++;
            snoop_at = c;
         end
         if (c == 1) begin
            check("snoop_op", {30'd0, bus.snoop_op}, {30'd0, op});
            check("snoop_addr", bus.snoop_addr, addr);
         end
         if (bus.mem_req) begin
            n_mem++;
            if (mem_at == 0) mem_at = c;
            if (bus.mem_we != (op == OP_WRITE)) we_bad++;
         end
         if (bus.rsp_valid) begin
            n_rsp++;
            rsp_at = c;
            if (exp_q.size() > 0) check("rsp_result", {30'd0, bus.rsp_result}, {30'd0, exp_q.pop_front()});
         end
         if (c <= c_d && bus.req_ready) busy_bad++;
         if (c == c_d + 1) check("ready_after_done", {31'd0, bus.req_ready}, 32'd1);
         @(posedge clk);
         #1;
      end
      idle_inputs();

      check("snoop_cnt", n_snoop, (op == OP_WRITE) ? 0 : 1);
      check("snoop_at", snoop_at, (op == OP_WRITE) ? 0 : 1);
      check("mem_cnt", n_mem, (op == OP_INV) ? 0 : ack_dly + 1);
      check("mem_at", mem_at, c_m);
      check("mem_we_bad", we_bad, 0);
      check("rsp_cnt", n_rsp, 1);
      check("rsp_at", rsp_at, c_d);
      check("busy_ready", busy_bad, 0);
      check("txn_count", txn_count, exp_txn);
      check("hitm_count", hitm_count, exp_hitm);
      check("rsp_missing", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Reset asserted for one edge while the responder sits in MEM.
   task automatic run_reset_mid();
      int n_rsp;
      bus.req_valid = 1'b1;
      bus.req_op    = OP_READ;
      bus.req_addr  = 32'h0000_2000;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      n_rsp = 0;
      for (int c = 1; c <= 4; c++) begin
         bus.snoop_valid = (c == 2) ? '1 : '0;
         bus.snoop_res   = {N_AGENTS{R_NOHIT}};
         @(negedge clk);
         if (c == 4) check("rst_pre_mem_req", {31'd0, bus.mem_req}, 32'd1);
         @(posedge clk);
         #1;
      end
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_rsp_result", {30'd0, bus.rsp_result}, {30'd0, R_NONE});
      check("rst_snoop_addr", bus.snoop_addr, 32'd0);
      check("rst_txn_count", txn_count, 32'd0);
      check("rst_hitm_count", hitm_count, 32'd0);
      for (int c = 0; c < 4; c++) begin
         if (bus.rsp_valid) n_rsp++;
         @(negedge clk);
      end
      check("rst_no_rsp", n_rsp, 0);
      exp_txn  = 0;
      exp_hitm = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic random_txn();
      logic [1:0] op;
      op = 2'($urandom);
      for (int i = 0; i < N_AGENTS; i++) begin
         if ($urandom_range(0, 3) == 0) rep_cyc[i] = $urandom_range(0, SNOOP_TIMEOUT + 2);
         else rep_cyc[i] = $urandom_range(1, 4);
         rep_res[i] = 2'($urandom_range(0, 3));
         dup_cyc[i] = 0;
         dup_res[i] = 2'($urandom_range(0, 3));
         if (rep_cyc[i] > 0 && $urandom_range(0, 2) == 0) dup_cyc[i] = rep_cyc[i] + $urandom_range(1, 3);
      end
      wb_dly  = $urandom_range(0, 4);
      ack_dly = $urandom_range(0, 3);
      spur    = 1'($urandom_range(0, 1));
      run_txn(op, $urandom);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      idle_inputs();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("reset_snoop_req", {31'd0, bus.snoop_req}, 32'd0);
      check("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("reset_rsp_result", {30'd0, bus.rsp_result}, {30'd0, R_NONE});
      check("reset_snoop_op", {30'd0, bus.snoop_op}, 32'd0);
      check("reset_snoop_addr", bus.snoop_addr, 32'd0);
      check("reset_txn_count", txn_count, 32'd0);
      check("reset_hitm_count", hitm_count, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // best-case READ: NOHIT, NOHIT, HIT all in the first COLLECT cycle
      set_agent(0, 1, R_NOHIT, 0, R_HIT);
      set_agent(1, 1, R_NOHIT, 0, R_HIT);
      set_agent(2, 1, R_HIT,   0, R_HIT);
      wb_dly = 0; ack_dly = 0; spur = 1'b0;
      run_txn(OP_READ, 32'h0000_1040);

      // RWIM with agent1 HITM, writeback three cycles after the reply
      set_agent(0, 1, R_NOHIT, 0, R_HIT);
      set_agent(1, 1, R_HITM,  0, R_HIT);
      set_agent(2, 1, R_NOHIT, 0, R_HIT);
      wb_dly = 2; ack_dly = 1; spur = 1'b1;
      run_txn(OP_RWIM, 32'h1234_5680);

      // INVALIDATE, everyone NOHIT (one via the reserved code 3)
      set_agent(0, 2, R_NOHIT, 0, R_HIT);
      set_agent(1, 1, R_NONE,  0, R_HIT);
      set_agent(2, 3, R_NOHIT, 0, R_HIT);
      wb_dly = 0; ack_dly = 0; spur = 1'b0;
      run_txn(OP_INV, 32'hABCD_0000);

      // WRITE: straight to memory
      set_agent(0, 0, R_HIT, 0, R_HIT);
      set_agent(1, 0, R_HIT, 0, R_HIT);
      set_agent(2, 0, R_HIT, 0, R_HIT);
      wb_dly = 0; ack_dly = 2; spur = 1'b1;
      run_txn(OP_WRITE, 32'hFFFF_FFC0);

      // timeout: only agent0 replies HIT, its later HITM duplicate is ignored
      set_agent(0, 1, R_HIT, 3, R_HITM);
      set_agent(1, 0, R_HIT, 0, R_HIT);
      set_agent(2, 0, R_HIT, 0, R_HIT);
      wb_dly = 0; ack_dly = 0; spur = 1'b0;
      run_txn(OP_READ, 32'h0000_0040);

      // reply arriving in the last allowed COLLECT cycle is still merged
      set_agent(0, 1, R_NOHIT, 0, R_HIT);
      set_agent(1, SNOOP_TIMEOUT, R_HITM, 0, R_HIT);
      set_agent(2, SNOOP_TIMEOUT + 1, R_HIT, 0, R_HIT);
      wb_dly = 0; ack_dly = 0; spur = 1'b1;
      run_txn(OP_READ, 32'h0F0F_0F00);

      for (int n = 0; n < 40; n++) random_txn();

      run_reset_mid();

      for (int n = 0; n < 15; n++) random_txn();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
